apple_spawn_ctrl: RTL and testbench
===================================

# apple_spawn_ctrl

Sequencing controller that places a new apple on the wall-mode playfield. On request it proposes pseudo-random candidate cells from an internal LFSR, screens each against the latched playfield bounds, and issues in-bounds cells to the external occupancy/wall checker. It retries on rejection and falls back to a deterministic row-major scan when the retry budget is spent. It sits between the game FSM (requester) and the registered apple/wall checking datapath (shared resource).

## Interface
- MAX_TRIES, 16, random candidates (out-of-bounds plus rejected) allowed before scan fallback; ≥1
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero
- clk  in  1  clock, rising edge
- nreset  in  1  reset, asynchronous, active-low
- req  in  1  request a new apple; sampled only in IDLE
- xmin, xmax, ymin, ymax  in  4 each  playfield bounds; cell (x,y) legal iff xmin<x<xmax and ymin<y<ymax
- chk_reject  in  1  checker verdict for the last issued candidate; valid in the cycle after cand_valid
- cand  out  8  candidate cell {y[3:0], x[3:0]} presented to checker
- cand_valid  out  1  one-cycle strobe: cand is to be checked
- apple_loc  out  8  last accepted apple cell
- apple_valid  out  1  one-cycle pulse: apple_loc updated
- busy  out  1  high in every state except IDLE
- fail  out  1  high when no legal free cell was found; cleared on the next accepted req

## Operation
- States: IDLE, GEN, ISSUE, WAIT, SCAN_ISSUE, SCAN_WAIT.
- IDLE: on req, latch bounds, clear tries and fail, go to GEN. A req while busy is ignored; a held req starts a new request on the first cycle back in IDLE.
- GEN: evaluate the current LFSR value. If in-bounds, load cand and go to ISSUE. Otherwise increment tries and stay in GEN; if tries reaches MAX_TRIES, go to scan start.
- ISSUE: cand_valid=1 for exactly this cycle, then go to WAIT.
- WAIT: sample chk_reject.
  - 0: load apple_loc<=cand, pulse apple_valid, go to IDLE.
  - 1: increment tries. If tries reaches MAX_TRIES, go to scan start; otherwise go to GEN.
- Scan start:
  - If xmin+1>=xmax or ymin+1>=ymax (no legal cell), set fail and go to IDLE.
  - Otherwise cand<={ymin+1, xmin+1} and go to SCAN_ISSUE.
- SCAN_ISSUE: cand_valid=1, then go to SCAN_WAIT.
- SCAN_WAIT:
  - chk_reject=0: accept, identical to WAIT.
  - chk_reject=1: advance row-major. x+1; at x=xmax-1, wrap to x=xmin+1 and y+1.
  - If the rejected cell was (xmax-1, ymax-1): set fail, go to IDLE, apple_loc unchanged.
- LFSR: 8-bit Fibonacci, q<={q[6:0], q[7]^q[5]^q[4]^q[3]}. Advances every clock in every state and never reaches zero.
- tries: width $clog2(MAX_TRIES+1) and saturating.
- Bounds arithmetic: 4-bit unsigned. Live bound inputs are ignored after latching.
- Reset (asynchronous, including mid-request):
  - State goes to IDLE and LFSR reloads LFSR_SEED.
  - cand, apple_loc=8'h00.
  - cand_valid, apple_valid, busy, fail=0.
  - Any in-flight check is abandoned.

## Timing
- Cycle N: req high in IDLE. N+1: GEN. N+2: ISSUE (cand_valid). N+3: WAIT (chk_reject sampled). N+4: apple_valid=1, apple_loc valid, busy=0.
- Minimum req-to-apple_valid latency is 4 cycles.
- Each rejected random candidate adds 3 cycles (WAIT→GEN→ISSUE→WAIT). Each out-of-bounds LFSR value adds 1 GEN cycle.
- Each rejected scan cell adds 2 cycles.
- cand is stable from ISSUE/SCAN_ISSUE through the following WAIT.
- cand_valid is never high on two consecutive cycles.
- apple_valid and fail are never asserted in the same request.
- fail rises in the cycle busy falls.

## Test plan
- Reset: hold nreset=0 with random inputs → all outputs 0, cand=apple_loc=8'h00. Release → busy=0; LFSR model matches from 8'hA5.
- Fast accept: bounds 0/15/0/15, chk_reject=0, req at N → cand_valid at N+2, apple_valid at N+4, apple_loc=cand. Cand matches the LFSR model and satisfies 0<x,y<15.
- Retry: same bounds, reject the first 3 issued candidates → 4 cand_valid strobes; apple_loc equals the 4th cand; tries below MAX_TRIES, so no scan.
- Scan fallback: bounds xmin=1, xmax=4, ymin=1, ymax=4, MAX_TRIES=2. Reject everything except 8'h32 (y=3, x=2).
  - Scan issues 8'h22, 8'h23, 8'h32 in order.
  - apple_loc=8'h32, fail=0.
- Fail: bounds xmin=3, xmax=4 → no cand_valid, fail=1 and busy=0 after MAX_TRIES GEN cycles. With legal bounds but all rejected → fail=1 after the last scan cell; apple_loc unchanged.
- Reset mid-WAIT and ignored req: assert nreset=0 in WAIT → immediate IDLE, no apple_valid. After release, req works normally. A req pulse during ISSUE is ignored: exactly one apple_valid results.

Source files
------------

// File: rtl/apple_spawn_ctrl.sv
// Apple placement controller: LFSR-driven candidate search with checker
// handshake, retry budget and a deterministic row-major scan fallback.
module apple_spawn_ctrl #(
    parameter int unsigned MAX_TRIES = 16,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       req,
    input  logic [3:0] xmin,
    input  logic [3:0] xmax,
    input  logic [3:0] ymin,
    input  logic [3:0] ymax,
    input  logic       chk_reject,
    output logic [7:0] cand,
    output logic       cand_valid,
    output logic [7:0] apple_loc,
    output logic       apple_valid,
    output logic       busy,
    output logic       fail
);

    localparam int unsigned   TRY_W   = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        ISSUE,
        WAIT,
        SCAN_ISSUE,
        SCAN_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [TRY_W-1:0]   tries_q, tries_d, tries_inc;
    logic [3:0]         xmin_q, xmax_q, ymin_q, ymax_q;
    logic [3:0]         xmin_d, xmax_d, ymin_d, ymax_d;
    logic [7:0]         cand_d, apple_loc_d;
    logic               cand_valid_d, apple_valid_d, busy_d, fail_d;

    logic [3:0]         xmin_p1, ymin_p1, xmax_m1, ymax_m1;
    logic               lfsr_inb, no_legal, scan_last, scan_go;
    logic [7:0]         scan_first, scan_next;

    // Bound-derived helpers, all in 4-bit unsigned arithmetic
    always_comb begin
        xmin_p1    = xmin_q + 4'd1;
        ymin_p1    = ymin_q + 4'd1;
        xmax_m1    = xmax_q - 4'd1;
        ymax_m1    = ymax_q - 4'd1;
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        lfsr_inb   = (lfsr_q[3:0] > xmin_q) && (lfsr_q[3:0] < xmax_q) &&
                     (lfsr_q[7:4] > ymin_q) && (lfsr_q[7:4] < ymax_q);
        no_legal   = (xmin_p1 >= xmax_q) || (ymin_p1 >= ymax_q);
        scan_first = {ymin_p1, xmin_p1};
        scan_last  = (cand == {ymax_m1, xmax_m1});
        scan_next  = (cand[3:0] == xmax_m1) ? {cand[7:4] + 4'd1, xmin_p1}
                                            : {cand[7:4], cand[3:0] + 4'd1};
        tries_inc  = (tries_q == TRY_MAX) ? tries_q : tries_q + TRY_W'(1);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        tries_d       = tries_q;
        xmin_d        = xmin_q;
        xmax_d        = xmax_q;
        ymin_d        = ymin_q;
        ymax_d        = ymax_q;
        cand_d        = cand;
        apple_loc_d   = apple_loc;
        fail_d        = fail;
        cand_valid_d  = 1'b0;
        apple_valid_d = 1'b0;
        scan_go       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    xmin_d  = xmin;
                    xmax_d  = xmax;
                    ymin_d  = ymin;
                    ymax_d  = ymax;
                    tries_d = '0;
                    fail_d  = 1'b0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (lfsr_inb) begin
                    cand_d       = lfsr_q;
                    cand_valid_d = 1'b1;
                    state_d      = ISSUE;
                end else begin
                    tries_d = tries_inc;
                    scan_go = (tries_inc == TRY_MAX);
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (!chk_reject) begin
                    apple_loc_d   = cand;
                    apple_valid_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tries_d = tries_inc;
                    if (tries_inc == TRY_MAX) scan_go = 1'b1;
                    else                      state_d = GEN;
                end
            end
            SCAN_ISSUE: state_d = SCAN_WAIT;
            SCAN_WAIT: begin
                if (!chk_reject) begin
                    apple_loc_d   = cand;
                    apple_valid_d = 1'b1;
                    state_d       = IDLE;
                end else if (scan_last) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cand_d       = scan_next;
                    cand_valid_d = 1'b1;
                    state_d      = SCAN_ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Retry budget spent: start the scan, or give up if the field has no interior
        if (scan_go) begin
            if (no_legal) begin
                fail_d  = 1'b1;
                state_d = IDLE;
            end else begin
                cand_d       = scan_first;
                cand_valid_d = 1'b1;
                state_d      = SCAN_ISSUE;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            tries_q     <= '0;
            xmin_q      <= 4'd0;
            xmax_q      <= 4'd0;
            ymin_q      <= 4'd0;
            ymax_q      <= 4'd0;
            cand        <= 8'h00;
            cand_valid  <= 1'b0;
            apple_loc   <= 8'h00;
            apple_valid <= 1'b0;
            busy        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            tries_q     <= tries_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            cand        <= cand_d;
            cand_valid  <= cand_valid_d;
            apple_loc   <= apple_loc_d;
            apple_valid <= apple_valid_d;
            busy        <= busy_d;
            fail        <= fail_d;
        end
    end

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Scoreboard bench for apple_spawn_ctrl: one instance with the default retry
// budget, one with MAX_TRIES=2 for scan-fallback and fail scenarios.
module tb_apple_spawn_ctrl;

    localparam int K_CAND  = 0;
    localparam int K_APPLE = 1;
    localparam int K_FAIL  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       nreset;
    logic       req[2];
    logic [3:0] xmin[2], xmax[2], ymin[2], ymax[2];
    logic       chk_reject[2];

    logic [7:0] cand0, cand1, apple_loc0, apple_loc1;
    logic       cand_valid0, cand_valid1, apple_valid0, apple_valid1;
    logic       busy0, busy1, fail0, fail1;

    ev_t        q0[$];
    ev_t        q1[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] mlfsr;
    logic [7:0] last_apple[2];
    int         n_apple[2];
    logic       pcv[2], pfail[2];
    int         drv_rej[2];
    bit         drv_acc_en[2];
    logic [7:0] drv_acc_val[2];

    apple_spawn_ctrl dut0 (
        .clk(clk), .nreset(nreset), .req(req[0]),
        .xmin(xmin[0]), .xmax(xmax[0]), .ymin(ymin[0]), .ymax(ymax[0]),
        .chk_reject(chk_reject[0]), .cand(cand0), .cand_valid(cand_valid0),
        .apple_loc(apple_loc0), .apple_valid(apple_valid0), .busy(busy0), .fail(fail0)
    );

    apple_spawn_ctrl #(.MAX_TRIES(2)) dut1 (
        .clk(clk), .nreset(nreset), .req(req[1]),
        .xmin(xmin[1]), .xmax(xmax[1]), .ymin(ymin[1]), .ymax(ymax[1]),
        .chk_reject(chk_reject[1]), .cand(cand1), .cand_valid(cand_valid1),
        .apple_loc(apple_loc1), .apple_valid(apple_valid1), .busy(busy1), .fail(fail1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) mlfsr <= 8'hA5;
        else         mlfsr <= step(mlfsr);
    end

    function automatic bit inb(input logic [7:0] v, input logic [3:0] xmn, xmx, ymn, ymx);
        return (v[3:0] > xmn) && (v[3:0] < xmx) && (v[7:4] > ymn) && (v[7:4] < ymx);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int kind, input logic [7:0] data, input int c);
        ev_t e;
        e.kind = kind; e.data = data; e.cyc = c;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference model: walks the request from the LFSR value seen in the first GEN cycle
    task automatic predict(input int d, input int maxt, input logic [3:0] xmn, xmx, ymn, ymx,
                           input logic [7:0] l1, input int t1, input int nrej,
                           input bit acc_en, input logic [7:0] acc_val);
        logic [7:0] v;
        logic [3:0] x, y, xp1, yp1, xm1, ym1;
        int t, tries, rej, ts;
        bit scan, done, rj;
        v = l1; t = t1; tries = 0; rej = nrej; scan = 0; done = 0;
        while (!done && !scan) begin
            if (inb(v, xmn, xmx, ymn, ymx)) begin
                push(d, K_CAND, v, t + 1);
                rj = (rej != 0) && !(acc_en && v == acc_val);
                if (rj && rej > 0) rej--;
                if (!rj) begin
                    push(d, K_APPLE, v, t + 3);
                    last_apple[d] = v;
                    done = 1;
                end else begin
                    tries++;
                    if (tries >= maxt) begin scan = 1; t = t + 2; end
                    else begin v = step(step(step(v))); t = t + 3; end
                end
            end else begin
                tries++;
                if (tries >= maxt) scan = 1;
                else begin v = step(v); t = t + 1; end
            end
        end
        if (scan) begin
            xp1 = xmn + 4'd1; yp1 = ymn + 4'd1; xm1 = xmx - 4'd1; ym1 = ymx - 4'd1;
            if (xp1 >= xmx || yp1 >= ymx) begin
                push(d, K_FAIL, last_apple[d], t + 1);
            end else begin
                x = xp1; y = yp1; ts = t + 1;
                for (int k = 0; k < 256; k++) begin
                    push(d, K_CAND, {y, x}, ts);
                    rj = (rej != 0) && !(acc_en && {y, x} == acc_val);
                    if (rj && rej > 0) rej--;
                    if (!rj) begin
                        push(d, K_APPLE, {y, x}, ts + 2);
                        last_apple[d] = {y, x};
                        break;
                    end
                    if ({y, x} == {ym1, xm1}) begin
                        push(d, K_FAIL, last_apple[d], ts + 2);
                        break;
                    end
                    if (x == xm1) begin x = xp1; y = y + 4'd1; end
                    else x = x + 4'd1;
                    ts = ts + 2;
                end
            end
        end
    endtask

    task automatic expect_ev(input int d, input int kind, input logic [7:0] data);
        ev_t e;
        int  sz;
        n_tests++;
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_fail++;
            $display("FAIL unexpected_event dut%0d: got kind=%0d data=%h cyc=%0d, expected none",
                     d, kind, data, cyc);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.kind != kind || e.data !== data || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL event dut%0d: got kind=%0d data=%h cyc=%0d expected kind=%0d data=%h cyc=%0d",
                     d, kind, data, cyc, e.kind, e.data, e.cyc);
        end
    endtask

    // Monitor plus checker-side responder for one instance
    task automatic mon(input int d, input logic cv, input logic [7:0] c, input logic av,
                       input logic [7:0] al, input logic b, input logic f);
        bit rj;
        if (cv) begin
            chk($sformatf("cand_valid_back_to_back dut%0d", d), 32'(pcv[d]), 32'd0);
            expect_ev(d, K_CAND, c);
            rj = (drv_rej[d] != 0) && !(drv_acc_en[d] && c == drv_acc_val[d]);
            if (rj && drv_rej[d] > 0) drv_rej[d]--;
            chk_reject[d] = rj;
        end
        if (av) begin
            expect_ev(d, K_APPLE, al);
            chk($sformatf("busy_at_apple dut%0d", d), 32'(b), 32'd0);
            chk($sformatf("fail_at_apple dut%0d", d), 32'(f), 32'd0);
            n_apple[d]++;
        end
        if (f && !pfail[d]) begin
            expect_ev(d, K_FAIL, al);
            chk($sformatf("busy_at_fail dut%0d", d), 32'(b), 32'd0);
        end
        pcv[d] = cv;
        pfail[d] = f;
    endtask

    always @(negedge clk) begin
        if (nreset) begin
            mon(0, cand_valid0, cand0, apple_valid0, apple_loc0, busy0, fail0);
            mon(1, cand_valid1, cand1, apple_valid1, apple_loc1, busy1, fail1);
        end else begin
            pcv[0] = 1'b0; pcv[1] = 1'b0; pfail[0] = 1'b0; pfail[1] = 1'b0;
        end
    end

    task automatic do_req(input int d, input logic [3:0] xmn, xmx, ymn, ymx,
                          input int nrej, input bit acc_en, input logic [7:0] acc_val);
        @(negedge clk);
        xmin[d] = xmn; xmax[d] = xmx; ymin[d] = ymn; ymax[d] = ymx;
        drv_rej[d] = nrej; drv_acc_en[d] = acc_en; drv_acc_val[d] = acc_val;
        req[d] = 1'b1;
        predict(d, (d == 0) ? 16 : 2, xmn, xmx, ymn, ymx, step(mlfsr), cyc + 1,
                nrej, acc_en, acc_val);
        @(negedge clk);
        req[d] = 1'b0;
        // Scramble live bounds; the latched copy must be used
        xmin[d] = 4'($urandom); xmax[d] = 4'($urandom);
        ymin[d] = 4'($urandom); ymax[d] = 4'($urandom);
    endtask

    task automatic drain(input int d);
        bit ok;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (((d == 0) ? q0.size() : q1.size()) == 0 &&
                ((d == 0) ? busy0 : busy1) == 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout dut%0d: %0d events still pending, expected 0", d,
                     (d == 0) ? q0.size() : q1.size());
            if (d == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  a0;
        bit  seen;
        nreset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            last_apple[d] = 8'h00; n_apple[d] = 0; pcv[d] = 0; pfail[d] = 0;
            drv_rej[d] = 0; drv_acc_en[d] = 0; drv_acc_val[d] = 8'h00;
        end
        // Reset with random inputs toggling
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                req[d] = 1'($urandom); chk_reject[d] = 1'($urandom);
                xmin[d] = 4'($urandom); xmax[d] = 4'($urandom);
                ymin[d] = 4'($urandom); ymax[d] = 4'($urandom);
            end
        end
        #1;
        chk("rst cand0", 32'(cand0), 32'h00);
        chk("rst apple_loc0", 32'(apple_loc0), 32'h00);
        chk("rst flags0", {28'd0, cand_valid0, apple_valid0, busy0, fail0}, 32'd0);
        chk("rst cand1", 32'(cand1), 32'h00);
        chk("rst apple_loc1", 32'(apple_loc1), 32'h00);
        chk("rst flags1", {28'd0, cand_valid1, apple_valid1, busy1, fail1}, 32'd0);
        req[0] = 0; req[1] = 0; chk_reject[0] = 0; chk_reject[1] = 0;
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst busy0", 32'(busy0), 32'd0);
        chk("post_rst busy1", 32'(busy1), 32'd0);

        do_req(0, 4'd0, 4'd15, 4'd0, 4'd15, 0, 0, 8'h00);   // fast accept
        drain(0);
        do_req(0, 4'd0, 4'd15, 4'd0, 4'd15, 3, 0, 8'h00);   // three rejects
        drain(0);
        do_req(0, 4'd4, 4'd12, 4'd2, 4'd9, 1, 0, 8'h00);    // tighter field, one reject
        drain(0);
        do_req(0, 4'd3, 4'd4, 4'd0, 4'd15, 0, 0, 8'h00);    // no legal column
        drain(0);
        chk("fail0 after empty field", 32'(fail0), 32'd1);

        // req pulse during ISSUE must be ignored
        a0 = n_apple[0];
        do_req(0, 4'd0, 4'd15, 4'd0, 4'd15, 0, 0, 8'h00);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (cand_valid0) begin seen = 1; break; end
            @(negedge clk);
            #1;
        end
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        drain(0);
        repeat (8) @(negedge clk);
        chk("apple count with ignored req", 32'(n_apple[0] - a0), 32'd1);
        chk("ignored req cand seen", 32'(seen), 32'd1);

        // Asynchronous reset while waiting on the checker
        do_req(0, 4'd0, 4'd15, 4'd0, 4'd15, 0, 0, 8'h00);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (cand_valid0) begin seen = 1; break; end
        end
        chk("midwait cand seen", 32'(seen), 32'd1);
        @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        chk("midwait busy", 32'(busy0), 32'd0);
        chk("midwait apple_loc", 32'(apple_loc0), 32'h00);
        chk("midwait pending", 32'(q0.size()), 32'd1);
        q0.delete();
        q1.delete();
        last_apple[0] = 8'h00;
        last_apple[1] = 8'h00;
        a0 = n_apple[0];
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midwait no apple", 32'(n_apple[0] - a0), 32'd0);
        do_req(0, 4'd0, 4'd15, 4'd0, 4'd15, 0, 0, 8'h00);
        drain(0);

        // Scan fallback and exhaustive rejection with MAX_TRIES=2
        do_req(1, 4'd1, 4'd4, 4'd1, 4'd4, -1, 1, 8'h32);
        drain(1);
        chk("scan apple_loc", 32'(apple_loc1), 32'h32);
        chk("scan fail", 32'(fail1), 32'd0);
        do_req(1, 4'd1, 4'd4, 4'd1, 4'd4, -1, 0, 8'h00);
        drain(1);
        chk("all_rejected fail", 32'(fail1), 32'd1);
        chk("all_rejected apple_loc", 32'(apple_loc1), 32'h32);
        do_req(1, 4'd9, 4'd10, 4'd0, 4'd15, 0, 0, 8'h00);
        drain(1);
        chk("empty field fail1", 32'(fail1), 32'd1);

        repeat (4) @(negedge clk);
        chk("queue0 empty", 32'(q0.size()), 32'd0);
        chk("queue1 empty", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
